// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel key synchroniser and debouncer with press, release and long-press pulses.
module key_debounce_multi #(
    parameter int N_KEYS     = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 12,
    parameter int LONG_CNT   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST_N,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Out,
    output logic [N_KEYS-1:0] Key_Press,
    output logic [N_KEYS-1:0] Key_Release,
    output logic [N_KEYS-1:0] Key_Long
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_CNT + 1);

    // Bit 0 of the state doubles as the registered debounced level.
    typedef enum logic [1:0] {RELEASED = 2'b00, PRESSED = 2'b01, LONG = 2'b11} state_t;

    logic [N_KEYS-1:0] sync_1, sync_2, sync;
    logic [TW-1:0]     tick_cnt;
    logic              tick;

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N)
        if (!Sys_RST_N) begin
            sync_1   <= {N_KEYS{ACTIVE_LOW}};
            sync_2   <= {N_KEYS{ACTIVE_LOW}};
            tick_cnt <= '0;
        end else begin
            sync_1   <= Key_In;
            sync_2   <= sync_1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end

    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    assign sync = ACTIVE_LOW ? ~sync_2 : sync_2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [DW-1:0] deb_cnt, deb_nxt;
        logic [HW-1:0] hold_cnt, hold_nxt;
        logic          press_q, rel_q, long_q, press_nxt, rel_nxt, long_nxt, flip;

        assign flip = tick && sync[i] != state[0] && deb_cnt == DW'(STABLE_CNT - 1);

        always_ff @(posedge Sys_CLK or negedge Sys_RST_N)
            if (!Sys_RST_N) begin
                state    <= RELEASED;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                state    <= state_nxt;
                deb_cnt  <= deb_nxt;
                hold_cnt <= hold_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                long_q   <= long_nxt;
            end

        // A debounced edge takes priority over the long-press threshold on the same tick.
        always_comb begin
            state_nxt = state;
            deb_nxt   = deb_cnt;
            hold_nxt  = hold_cnt;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            long_nxt  = 1'b0;
            if (tick)
                deb_nxt = (sync[i] == state[0] || flip) ? '0 : deb_cnt + 1'b1;
            if (flip) begin
                state_nxt = sync[i] ? PRESSED : RELEASED;
                press_nxt = sync[i];
                rel_nxt   = !sync[i];
                hold_nxt  = '0;
            end else if (tick && state == PRESSED) begin
                hold_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HW'(LONG_CNT - 1)) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
        end

        assign Key_Out[i]     = state[0];
        assign Key_Press[i]   = press_q;
        assign Key_Release[i] = rel_q;
        assign Key_Long[i]    = long_q;
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: randomized and directed stimulus on an active-high and an active-low instance,
// checked against a tick-level reference model through an event scoreboard.
module tb_key_debounce_multi;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int LC = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pin_a, pin_b;
    logic [1:0] out_a, pr_a, rl_a, lg_a;
    logic [1:0] out_b, pr_b, rl_b, lg_b;

    always #5 clk = ~clk;

    key_debounce_multi #(.N_KEYS(2), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC), .ACTIVE_LOW(1'b0)) dut_a (
        .Sys_CLK(clk), .Sys_RST_N(rst_n), .Key_In(pin_a),
        .Key_Out(out_a), .Key_Press(pr_a), .Key_Release(rl_a), .Key_Long(lg_a)
    );

    key_debounce_multi #(.N_KEYS(2), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC), .ACTIVE_LOW(1'b1)) dut_b (
        .Sys_CLK(clk), .Sys_RST_N(rst_n), .Key_In(pin_b),
        .Key_Out(out_b), .Key_Press(pr_b), .Key_Release(rl_b), .Key_Long(lg_b)
    );

    typedef struct packed {
        int         cyc;
        logic [1:0] pa, ra, la, pb, rb, lb;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0, errors = 0, scyc = 0, mcyc = 0;

    // Reference model: pins delayed two cycles, a global tick index, and per key the tick at which
    // the sampled pin last agreed with the level and the tick of the last press.
    logic [1:0] m_p1 [2], m_p2 [2], m_lvl [2], m_done [2], exp_out [2];
    int         last_eq [2][2], press_tk [2][2];
    int         m_tc, m_ticks;

    task automatic model_step(input logic [1:0] a, input logic [1:0] b, input logic rn);
        logic [1:0] pin [2];
        logic [1:0] pr [2], rl [2], lg [2];
        logic       s;
        bit         tk, flip;
        ev_t        e;
        pin[0] = a;
        pin[1] = b;
        if (!rn) begin
            for (int u = 0; u < 2; u++) begin
                m_p1[u]    = (u == 1) ? 2'b11 : 2'b00;
                m_p2[u]    = m_p1[u];
                m_lvl[u]   = 2'b00;
                m_done[u]  = 2'b00;
                exp_out[u] = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    last_eq[u][c]  = 0;
                    press_tk[u][c] = 0;
                end
            end
            m_tc    = 0;
            m_ticks = 0;
            return;
        end
        tk = (m_tc == TD - 1);
        if (tk) m_ticks++;
        for (int u = 0; u < 2; u++) begin
            pr[u] = 2'b00;
            rl[u] = 2'b00;
            lg[u] = 2'b00;
            for (int c = 0; c < 2; c++) begin
                s = m_p2[u][c] ^ (u == 1);
                if (tk) begin
                    flip = 1'b0;
                    if (s == m_lvl[u][c]) last_eq[u][c] = m_ticks;
                    else if (m_ticks - last_eq[u][c] >= SC) begin
                        flip          = 1'b1;
                        m_lvl[u][c]   = s;
                        last_eq[u][c] = m_ticks;
                        if (s) begin
                            pr[u][c]       = 1'b1;
                            press_tk[u][c] = m_ticks;
                            m_done[u][c]   = 1'b0;
                        end else rl[u][c] = 1'b1;
                    end
                    if (!flip && m_lvl[u][c] && !m_done[u][c] && m_ticks - press_tk[u][c] == LC) begin
                        lg[u][c]     = 1'b1;
                        m_done[u][c] = 1'b1;
                    end
                end
            end
            exp_out[u] = m_lvl[u];
            m_p2[u]    = m_p1[u];
            m_p1[u]    = pin[u];
        end
        m_tc = (m_tc + 1) % TD;
        if (|{pr[0], rl[0], lg[0], pr[1], rl[1], lg[1]}) begin
            e.cyc = scyc + 1;
            e.pa = pr[0]; e.ra = rl[0]; e.la = lg[0];
            e.pb = pr[1]; e.rb = rl[1]; e.lb = lg[1];
            exp_q.push_back(e);
        end
    endtask

    task automatic go(input logic [1:0] a, input logic [1:0] b, input logic rn);
        pin_a = a;
        pin_b = b;
        rst_n = rn;
        model_step(a, b, rn);
        scyc++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] a, input logic [1:0] b, input int n);
        for (int k = 0; k < n; k++) go(a, b, 1'b1);
    endtask

    task automatic expect2(input string nm, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mcyc++;
        checks += 2;
        if (out_a !== exp_out[0]) begin
            errors++;
            $display("FAIL level_a cyc %0d: Key_Out %b required %b", mcyc, out_a, exp_out[0]);
        end
        if (out_b !== exp_out[1]) begin
            errors++;
            $display("FAIL level_b cyc %0d: Key_Out %b required %b", mcyc, out_b, exp_out[1]);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < mcyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event cyc %0d: required at cyc %0d", mcyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (|{pr_a, rl_a, lg_a, pr_b, rl_b, lg_b} || (exp_q.size() > 0 && exp_q[0].cyc == mcyc)) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != mcyc) begin
                errors++;
                $display("FAIL spurious_event cyc %0d: press %b/%b release %b/%b long %b/%b",
                         mcyc, pr_a, pr_b, rl_a, rl_b, lg_a, lg_b);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pr_a, rl_a, lg_a, pr_b, rl_b, lg_b} !== {mon_e.pa, mon_e.ra, mon_e.la, mon_e.pb, mon_e.rb, mon_e.lb}) begin
                    errors++;
                    $display("FAIL events cyc %0d: got a p%b r%b l%b b p%b r%b l%b, required a p%b r%b l%b b p%b r%b l%b",
                             mcyc, pr_a, rl_a, lg_a, pr_b, rl_b, lg_b,
                             mon_e.pa, mon_e.ra, mon_e.la, mon_e.pb, mon_e.rb, mon_e.lb);
                end
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < 4; k++) go(2'b11, 2'b11, 1'b0);
        expect2("reset_out_a", out_a, 2'b00);
        expect2("reset_press_a", pr_a, 2'b00);
        expect2("reset_out_b", out_b, 2'b00);
        hold(2'b11, 2'b11, 20);
        expect2("both_pressed_a", out_a, 2'b11);
        expect2("inactive_b", out_b, 2'b00);
        hold(2'b00, 2'b11, 20);
        expect2("released_a", out_a, 2'b00);
        // Bounce: two ticks high, one low, then a full window high.
        hold(2'b01, 2'b11, 8);
        hold(2'b00, 2'b11, 4);
        hold(2'b01, 2'b11, 16);
        expect2("bounce_a", out_a, 2'b01);
        hold(2'b00, 2'b11, 20);
        hold(2'b10, 2'b11, 7);
        expect2("glitch_a", out_a, 2'b00);
        hold(2'b00, 2'b11, 20);
        hold(2'b01, 2'b11, 48);
        hold(2'b00, 2'b11, 20);
        // Aligned press of key 0 and release of key 1; instance b sees key 0 pulled low.
        hold(2'b10, 2'b11, 20);
        hold(2'b01, 2'b10, 20);
        expect2("coincide_a", out_a, 2'b01);
        expect2("active_low_b", out_b, 2'b01);
        hold(2'b00, 2'b11, 20);
        n = 0;
        while (exp_out[0][0] !== 1'b1 && n < 40) begin
            go(2'b01, 2'b11, 1'b1);
            n++;
        end
        hold(2'b01, 2'b11, 9);
        expect2("pre_reset_a", out_a, 2'b01);
        rst_n = 1'b0;
        #1;
        expect2("async_reset_a", out_a, 2'b00);
        go(2'b01, 2'b11, 1'b0);
        go(2'b01, 2'b11, 1'b0);
        hold(2'b01, 2'b11, 8);
        expect2("fresh_window_a", out_a, 2'b00);
        hold(2'b01, 2'b11, 8);
        expect2("fresh_press_a", out_a, 2'b01);
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                go(pin_a, pin_b, 1'b0);
                go(pin_a, pin_b, 1'b0);
            end
            hold(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 60));
        end
        hold(2'b00, 2'b11, 40);
        expect2("drained_a", out_a, 2'b00);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Multi-channel push-button conditioner: synchronises N raw key inputs, debounces each with a programmable stability window, and emits a debounced level plus single-cycle press, release and long-press event pulses. It is a parametrised successor to the 2-key, fixed 12-sample debouncer. All logic runs on Sys_CLK using a sample-enable tick; no derived clock is generated. It sits between board pins and the control FSMs that consume key events.

## Interface
- N_KEYS, 4: number of independent key channels (≥1).
- TICK_DIV, 50000: Sys_CLK cycles per sample tick (≥2); 50000 gives 1 ms at 50 MHz.
- STABLE_CNT, 12: consecutive ticks a new input value must persist before the debounced level changes (≥1).
- LONG_CNT, 1000: ticks of continuous debounced press before the long-press pulse fires (≥1).
- ACTIVE_LOW, 0: 1 = pressed key drives pin low; input is inverted after synchronisation.
- Sys_CLK  input  1  system clock.
- Sys_RST_N  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- Key_In  input  N_KEYS  raw asynchronous key pins.
- Key_Out  output  N_KEYS  debounced level, 1 = pressed.
- Key_Press  output  N_KEYS  one-cycle pulse when Key_Out rises.
- Key_Release  output  N_KEYS  one-cycle pulse when Key_Out falls.
- Key_Long  output  N_KEYS  one-cycle pulse when a press has been held LONG_CNT ticks.

## Operation
- Synchroniser: 2 flops per channel; reset value = inactive pin level (ACTIVE_LOW ? 1 : 0). Polarity applied after 2nd flop → Sync[i] (1 = pressed).
- Tick generator (shared): Tick_Cnt, width clog2(TICK_DIV); counts 0..TICK_DIV-1, wraps to 0; Tick = 1 for exactly one cycle when Tick_Cnt == TICK_DIV-1.
- Debounce per channel, evaluated only on Tick, Deb_Cnt width clog2(STABLE_CNT+1):
  - Sync[i] == Key_Out[i]: Deb_Cnt ← 0 (any glitch restarts the window).
  - Sync[i] != Key_Out[i] and Deb_Cnt == STABLE_CNT-1: Key_Out[i] ← Sync[i], Deb_Cnt ← 0.
  - otherwise Deb_Cnt ← Deb_Cnt+1.
- Per-channel state: RELEASED (Key_Out=0), PRESSED (Key_Out=1, Hold_Cnt < LONG_CNT), LONG (Key_Out=1, long pulse already issued).
  - RELEASED→PRESSED on debounced rise: Key_Press=1, Hold_Cnt ← 0.
  - PRESSED: each Tick, Hold_Cnt+1; on reaching LONG_CNT → LONG, Key_Long=1.
  - PRESSED/LONG→RELEASED on debounced fall: Key_Release=1, Hold_Cnt ← 0.
  - LONG: Hold_Cnt saturates; no further Key_Long until released and pressed again.
- Hold_Cnt width clog2(LONG_CNT+1); never wraps.
- Channels fully independent; simultaneous events on several channels all reported in the same cycle.

## Timing
- Reset (async assert, sync release): Key_Out, Key_Press, Key_Release, Key_Long = 0; Tick_Cnt, Deb_Cnt, Hold_Cnt = 0; all channels RELEASED. Reset mid-press drops Key_Out without a Key_Release pulse.
- All outputs registered; event pulses high exactly one Sys_CLK cycle, in the same cycle Key_Out (or state) changes, i.e. the cycle after the deciding Tick.
- Press latency from stable pin edge: 2 sync cycles + up to STABLE_CNT ticks + 1 cycle; release identical.
- Key_Long fires LONG_CNT ticks after the Key_Press cycle (first tick after press counts as 1).
- A pin toggle shorter than STABLE_CNT ticks never changes Key_Out and produces no pulses.
- If the long threshold and a debounced fall coincide on the same tick, release wins: Key_Release=1, Key_Long=0.

## Test plan
Bench parameters: N_KEYS=2, TICK_DIV=4, STABLE_CNT=3, LONG_CNT=5, ACTIVE_LOW=0.
- Reset: hold Sys_RST_N=0 with Key_In=2'b11 → all outputs 0; release reset, Key_In steady 1 → Key_Out[1:0]=2'b11 after 3 ticks, Key_Press=2'b11 for one cycle.
- Bounce: Key_In[0] high 2 ticks, low 1 tick, high 3 ticks → Key_Out[0] rises only after the final 3-tick run; exactly one Key_Press[0] pulse.
- Short glitch: Key_In[1] high for 7 Sys_CLK cycles → Key_Out[1], Key_Press[1], Key_Release[1] stay 0.
- Long press: Key_In[0] held 12 ticks → Key_Press[0] once, Key_Long[0] once exactly 5 ticks later, no second Key_Long; release → one Key_Release[0] after 3 ticks.
- Independence/coincidence: press key 0 and release key 1 with aligned edges → Key_Press[0] and Key_Release[1] in the same cycle; with ACTIVE_LOW=1, pin low for 3 ticks → Key_Out=1.
- Async reset mid-press (Key_Out[0]=1, Hold_Cnt=2) → Key_Out[0]=0 immediately, no Key_Release pulse; after release, fresh press requires full 3-tick window.
